// File: rtl/mips_control_unit.sv
// Moore multicycle control FSM for a 16-bit MIPS-style datapath.
// Each state drives the datapath selects and enables for one cycle of an instruction.
module mips_control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic [2:0] funk,
    output logic [1:0] ALUOp,
    output logic       SrcA,
    output logic [1:0] SrcB,
    output logic [1:0] MemtoReg,
    output logic       RegDest,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       MemSrc,
    output logic       OutputWrite,
    output logic       BranchCond,
    output logic [4:0] current_state,
    output logic [4:0] next_state
);

    // state     | meaning
    // S_FETCH   | read instruction, PC <= PC + 2
    // S_DECODE  | register read, branch target into ALUOut
    // S_REXEC   | R-type ALU operation
    // S_RWB     | R-type write-back to rd
    // S_ADDI    | add immediate
    // S_IWB     | immediate write-back to rt
    // S_MADDR   | load/store address calculation
    // S_LWRD    | load memory read
    // S_LWWB    | load write-back
    // S_SW      | store memory write
    // S_BEQ     | compare, conditional PC load
    // S_JUMP    | jump
    // S_LUI     | load upper immediate write-back
    // S_OUT     | output-port write
    // S_JR      | jump register
    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_REXEC  = 5'd2,
        S_RWB    = 5'd3,
        S_ADDI   = 5'd4,
        S_IWB    = 5'd5,
        S_MADDR  = 5'd6,
        S_LWRD   = 5'd7,
        S_LWWB   = 5'd8,
        S_SW     = 5'd9,
        S_BEQ    = 5'd10,
        S_JUMP   = 5'd12,
        S_LUI    = 5'd13,
        S_OUT    = 5'd14,
        S_JR     = 5'd15
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign current_state = state_q;
    assign next_state    = state_d;

    always_comb begin
        state_d     = S_FETCH;
        ALUOp       = 2'b00;
        SrcA        = 1'b0;
        SrcB        = 2'b00;
        MemtoReg    = 2'b00;
        RegDest     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 2'b00;
        MemSrc      = 1'b0;
        OutputWrite = 1'b0;
        BranchCond  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                SrcB    = 2'b01;
                PCWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                SrcB = 2'b11;
                case (Opcode)
                    4'd0:       state_d = (funk == 3'b111) ? S_JR : S_REXEC;
                    4'd1:       state_d = S_ADDI;
                    4'd2, 4'd3: state_d = S_MADDR;
                    4'd4:       state_d = S_BEQ;
                    4'd6:       state_d = S_JUMP;
                    4'd7:       state_d = S_LUI;
                    4'd8:       state_d = S_OUT;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_REXEC: begin
                SrcA    = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDest  = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDI: begin
                SrcA    = 1'b1;
                SrcB    = 2'b10;
                state_d = S_IWB;
            end
            S_IWB: RegWrite = 1'b1;
            S_MADDR: begin
                SrcA = 1'b1;
                SrcB = 2'b10;
                // IR is stable for the whole instruction; anything else falls back to fetch
                if (Opcode == 4'd2)      state_d = S_LWRD;
                else if (Opcode == 4'd3) state_d = S_SW;
                else                     state_d = S_FETCH;
            end
            S_LWRD: begin
                MemRead = 1'b1;
                MemSrc  = 1'b1;
                state_d = S_LWWB;
            end
            S_LWWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_SW: begin
                MemWrite = 1'b1;
                MemSrc   = 1'b1;
            end
            S_BEQ: begin
                SrcA       = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                BranchCond = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_OUT: begin
                SrcA        = 1'b1;
                OutputWrite = 1'b1;
            end
            S_JR: begin
                PCSrc   = 2'b11;
                PCWrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// Bench for mips_control_unit: spec vectors, randomized instruction stream, async reset aborts.
module tb_mips_control_unit;

    logic       CLK;
    logic       Reset;
    logic [3:0] Opcode;
    logic [2:0] funk;
    logic [1:0] ALUOp, SrcB, MemtoReg, PCSrc;
    logic       SrcA, RegDest, RegWrite, MemRead, MemWrite, IRWrite, PCWrite;
    logic       MemSrc, OutputWrite, BranchCond;
    logic [4:0] current_state, next_state;

    int total = 0;
    int bad   = 0;
    int path[$];

    mips_control_unit dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .funk(funk),
        .ALUOp(ALUOp), .SrcA(SrcA), .SrcB(SrcB), .MemtoReg(MemtoReg),
        .RegDest(RegDest), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .MemSrc(MemSrc), .OutputWrite(OutputWrite),
        .BranchCond(BranchCond), .current_state(current_state),
        .next_state(next_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [17:0] dut_out;
    assign dut_out = {ALUOp, SrcA, SrcB, MemtoReg, RegDest, RegWrite, MemRead,
                      MemWrite, IRWrite, PCWrite, PCSrc, MemSrc, OutputWrite, BranchCond};

    // Expected control word for a state, straight from the per-state output list.
    function automatic logic [17:0] exp_out(input int s);
        logic [1:0] aluop, srcb, m2r, pcsrc;
        logic srca, rd, rw, mr, mw, irw, pcw, ms, ow, bc;
        {aluop, srcb, m2r, pcsrc} = '0;
        {srca, rd, rw, mr, mw, irw, pcw, ms, ow, bc} = '0;
        case (s)
            0:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; aluop = 2'b10; end
            3:  begin rd = 1; rw = 1; end
            4:  begin srca = 1; srcb = 2'b10; end
            5:  rw = 1;
            6:  begin srca = 1; srcb = 2'b10; end
            7:  begin mr = 1; ms = 1; end
            8:  begin m2r = 2'b01; rw = 1; end
            9:  begin mw = 1; ms = 1; end
            10: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; bc = 1; end
            12: begin pcsrc = 2'b10; pcw = 1; end
            13: begin m2r = 2'b10; rw = 1; end
            14: begin srca = 1; ow = 1; end
            15: begin pcsrc = 2'b11; pcw = 1; end
            default: ;
        endcase
        return {aluop, srca, srcb, m2r, rd, rw, mr, mw, irw, pcw, pcsrc, ms, ow, bc};
    endfunction

    // Instruction-level reference: the full visit list of one instruction, starting at fetch.
    task automatic build_path(input logic [3:0] op, input logic [2:0] f);
        path = {0, 1};
        case (op)
            4'd0: if (f == 3'b111) path.push_back(15);
                  else begin path.push_back(2); path.push_back(3); end
            4'd1: begin path.push_back(4); path.push_back(5); end
            4'd2: begin path.push_back(6); path.push_back(7); path.push_back(8); end
            4'd3: begin path.push_back(6); path.push_back(9); end
            4'd4: path.push_back(10);
            4'd6: path.push_back(12);
            4'd7: path.push_back(13);
            4'd8: path.push_back(14);
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge with the DUT in fetch; leaves at the negedge of the next fetch.
    task automatic run_path(input logic [3:0] op, input logic [2:0] f, input string tag);
        for (int i = 0; i < path.size(); i++) begin
            if (i > 0) @(negedge CLK);
            if (i == 0) begin Opcode = op; funk = f; end
            #1;
            chk({tag, " state"}, 32'(current_state), 32'(path[i]));
            chk({tag, " outputs"}, 32'(dut_out), 32'(exp_out(path[i])));
            chk({tag, " next"}, 32'(next_state),
                32'((i + 1 < path.size()) ? path[i + 1] : 0));
        end
        @(negedge CLK);
    endtask

    // Run k cycles into an instruction, then assert Reset between edges.
    task automatic reset_mid(input logic [3:0] op, input logic [2:0] f, input int k,
                             input int exp_state, input string tag);
        Opcode = op; funk = f;
        repeat (k) @(negedge CLK);
        #1;
        chk({tag, " pre-reset state"}, 32'(current_state), 32'(exp_state));
        #1 Reset = 1'b1;
        #1;
        chk({tag, " async state"}, 32'(current_state), 32'd0);
        chk({tag, " async outputs"}, 32'(dut_out), 32'(exp_out(0)));
        chk({tag, " async next"}, 32'(next_state), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, " held state"}, 32'(current_state), 32'd0);
        chk({tag, " no write"}, 32'({RegWrite, MemWrite}), 32'd0);
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]      op;
        logic [2:0]      f;
        int              len;
        logic [5:0][4:0] seq;
        string           name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'd0,  3'b000, 4, {5'd0, 5'd0, 5'd3,  5'd2,  5'd1, 5'd0}, "rtype"};
        vecs[1]  = '{4'd2,  3'b000, 5, {5'd0, 5'd8, 5'd7,  5'd6,  5'd1, 5'd0}, "lw"};
        vecs[2]  = '{4'd3,  3'b010, 4, {5'd0, 5'd0, 5'd9,  5'd6,  5'd1, 5'd0}, "sw"};
        vecs[3]  = '{4'd4,  3'b000, 3, {5'd0, 5'd0, 5'd0,  5'd10, 5'd1, 5'd0}, "beq"};
        vecs[4]  = '{4'd0,  3'b111, 3, {5'd0, 5'd0, 5'd0,  5'd15, 5'd1, 5'd0}, "jr"};
        vecs[5]  = '{4'd12, 3'b000, 2, {5'd0, 5'd0, 5'd0,  5'd0,  5'd1, 5'd0}, "undef12"};
        vecs[6]  = '{4'd1,  3'b101, 4, {5'd0, 5'd0, 5'd5,  5'd4,  5'd1, 5'd0}, "addi"};
        vecs[7]  = '{4'd6,  3'b000, 3, {5'd0, 5'd0, 5'd0,  5'd12, 5'd1, 5'd0}, "jump"};
        vecs[8]  = '{4'd7,  3'b000, 3, {5'd0, 5'd0, 5'd0,  5'd13, 5'd1, 5'd0}, "lui"};
        vecs[9]  = '{4'd8,  3'b000, 3, {5'd0, 5'd0, 5'd0,  5'd14, 5'd1, 5'd0}, "out"};
        vecs[10] = '{4'd5,  3'b111, 2, {5'd0, 5'd0, 5'd0,  5'd0,  5'd1, 5'd0}, "undef5"};

        Reset = 1'b1; Opcode = 4'd0; funk = 3'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset state", 32'(current_state), 32'd0);
        chk("reset outputs", 32'(dut_out), 32'(exp_out(0)));
        chk("reset next", 32'(next_state), 32'd1);
        Reset = 1'b0;

        foreach (vecs[v]) begin
            path = {};
            for (int i = 0; i < vecs[v].len; i++) path.push_back(int'(vecs[v].seq[i]));
            run_path(vecs[v].op, vecs[v].f, vecs[v].name);
        end

        reset_mid(4'd2, 3'd0, 3, 7, "abort lw");
        path = {0, 1, 6, 7, 8};
        run_path(4'd2, 3'd0, "lw after abort");
        reset_mid(4'd3, 3'd0, 3, 9, "abort sw");
        reset_mid(4'd0, 3'd0, 3, 3, "abort rwb");

        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            logic [2:0] f;
            op = 4'($urandom_range(0, 15));
            f  = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            build_path(op, f);
            run_path(op, f, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
